// File: rtl/concat_order_pkg.sv
// Shared constants for the ordered-concatenation FIFO: order-mode codes and
// the occupancy-state encoding used by the top-level FSM.
package concat_order_pkg;

    localparam logic [1:0] MODE_DC   = 2'b00;
    localparam logic [1:0] MODE_CD   = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b10;
    localparam logic [1:0] MODE_INV  = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } occ_state_e;

endpackage

// File: rtl/concat_order_pack.sv
// Combinational word formation: orders or inverts the two operands, or
// repeats the previously pushed word.
module concat_order_pack
    import concat_order_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0]   c_i,
    input  logic [W-1:0]   d_i,
    input  logic [1:0]     mode_i,
    input  logic [2*W-1:0] last_word_i,
    output logic [2*W-1:0] word_o
);

    always_comb begin
        word_o = last_word_i;
        case (mode_i)
            MODE_DC:   word_o = {d_i, c_i};
            MODE_CD:   word_o = {c_i, d_i};
            MODE_HOLD: word_o = last_word_i;
            MODE_INV:  word_o = {~d_i, ~c_i};
            default:   word_o = last_word_i;
        endcase
    end

endmodule

// File: rtl/concat_order_fifo.sv
// Ordered-concatenation FIFO: forms 2W-bit words from c/d/mode, buffers them in
// a DEPTH-entry FIFO, and keeps a ~d tap and a wrapping transaction counter.
module concat_order_fifo
    import concat_order_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   c,
    input  logic [W-1:0]   d,
    input  logic [1:0]     mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_data,
    output logic [W-1:0]   x_tap,
    output logic [CW-1:0]  txn_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);
    localparam logic [NW-1:0] ONE_CNT  = NW'(1);

    logic [2*W-1:0] mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]  count_q, count_d;
    logic [2*W-1:0] last_word_q;
    logic [W-1:0]   x_tap_q;
    logic [CW-1:0]  txn_cnt_q;
    occ_state_e     state_q, state_d;

    logic           push, pop;
    logic [2*W-1:0] word;

    concat_order_pack #(.W(W)) u_pack (
        .c_i         (c),
        .d_i         (d),
        .mode_i      (mode),
        .last_word_i (last_word_q),
        .word_o      (word)
    );

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_q[rd_ptr_q];
    assign x_tap     = x_tap_q;
    assign txn_cnt   = txn_cnt_q;

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = (DEPTH == 1) ? ST_FULL : ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (push && !pop && (count_q == FULL_CNT - ONE_CNT)) begin
                    state_d = ST_FULL;
                end else if (pop && !push && (count_q == ONE_CNT)) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = (DEPTH == 1) ? ST_EMPTY : ST_PARTIAL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_word_q <= '0;
            x_tap_q     <= '0;
            txn_cnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                last_word_q <= word;
                x_tap_q     <= ~d;
                txn_cnt_q   <= txn_cnt_q + 1'b1;
            end
        end
    end

    // Storage is cleared on reset so the head reads 0 right after reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

endmodule

// File: doc/concat_order_fifo.md
Name: concat_order_fifo

Overview:
- Parametrised, sequential successor to the two-input ordered-concatenation block.
- Accepts two W-bit operands c and d with a per-transaction order mode and forms a 2W-bit packed word. The word is either {d,c}, {c,d}, a bitwise-inverted form, or a repeat of the previous word.
- Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Provides a registered ~d side tap and a wrapping transaction counter, so coverage diags can exercise FSM, FIFO and counter logic.

Parameters:
- W, 1, width of each operand c and d.
- DEPTH, 2, number of FIFO entries; any value >= 1, not required to be a power of two.
- CW, 16, width of the accepted-transaction counter.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand transaction is presented.
- in_ready  output  1  block can accept a transaction this cycle.
- c  input  W  low operand in normal order.
- d  input  W  high operand in normal order.
- mode  input  2  00 = {d,c}; 01 = {c,d}; 10 = hold (repeat last word); 11 = {~d,~c}.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head.
- out_data  output  2W  FIFO head word.
- x_tap  output  W  registered ~d of the last accepted transaction.
- txn_cnt  output  CW  number of accepted transactions, modulo 2^CW.

Behaviour:
- Reset: when reset_n=0 at a rising edge, the following are cleared: FIFO pointers, occupancy count, last_word, x_tap and txn_cnt.
  - Outputs during and after reset: out_valid=0, in_ready=1, out_data=0, x_tap=0, txn_cnt=0.
  - Reset mid-operation discards all buffered words. There is no partial pop.
- Accept: push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH). in_ready does not depend on out_ready, so there is no full-and-pop pass-through.
- Word formation on push:
  - mode 00 gives {d,c}.
  - mode 01 gives {c,d}.
  - mode 11 gives {~d,~c}.
  - mode 10 gives last_word. Immediately after reset, last_word is 0.
- last_word is updated to the pushed word on every push, including a hold push, which rewrites the same value.
- x_tap is updated to ~d on every push, regardless of mode, and holds when there is no push.
- txn_cnt increments by 1 per push and wraps from 2^CW-1 to 0.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N when the FIFO was empty. This is 1-cycle latency; there is no combinational in-to-out path.
- out_data is the FIFO head and is stable while out_valid=1 and out_ready=0.
- Occupancy:
  - count increments on push only and decrements on pop only.
  - count is unchanged on simultaneous push and pop, which is legal at any count between 1 and DEPTH-1.
- Empty: out_valid=0. out_data shows the head slot's stale contents, and the bench ignores it.
- Full: in_ready=0 and in_valid is ignored. A pop in that cycle makes in_ready=1 on the next cycle.
- Pointers: wr_ptr and rd_ptr are modulo DEPTH, wrapping from DEPTH-1 to 0 by explicit compare, not bit truncation.
- FSM (occupancy state, mirrors count):
  - States: EMPTY, PARTIAL, FULL.
  - EMPTY -> PARTIAL on push, or directly to FULL on push when DEPTH=1.
  - PARTIAL -> FULL when a push without pop makes count=DEPTH.
  - PARTIAL -> EMPTY when a pop without push makes count=0.
  - FULL -> PARTIAL (or EMPTY when DEPTH=1) on pop.
  - out_valid = (state != EMPTY). in_ready = (state != FULL).
- An invalid mode is impossible (2-bit, fully decoded). X on mode with in_valid=1 is a bench error.

Decomposition:
- Shared package concat_order_pkg holds:
  - mode constants MODE_DC=2'b00, MODE_CD=2'b01, MODE_HOLD=2'b10, MODE_INV=2'b11;
  - occupancy state encoding ST_EMPTY, ST_PARTIAL, ST_FULL.
- One natural sub-module, concat_order_pack: combinational word formation from c, d, mode and last_word.
- FIFO storage, pointers, FSM, x_tap and txn_cnt stay in the top module.

Test Plan:
- W=1, DEPTH=2. Reset, then push c=0,d=1 with mode 00, then mode 01, with out_ready=1 -> out_data=2'b10 then 2'b01; x_tap=0; txn_cnt=2.
- W=4. Reset, then the first push with mode 10 -> out_data=8'h00. Next, push c=4'h3,d=4'hA with mode 00, then a push with mode 10 -> out_data 8'hA3, then 8'hA3.
- W=4, mode 11, c=4'h3,d=4'hA -> out_data=8'h5C, x_tap=4'h5.
- DEPTH=3, out_ready=0. Push 4 words back-to-back -> in_ready drops after the 3rd push, the 4th is not accepted, and txn_cnt=3. Then raise out_ready -> heads come out in order, in_ready=1 one cycle after the first pop.
- DEPTH=3, continuous push and pop for 10 transactions -> count stays 1, all pointer wraps are exercised, and output order matches input.
- Fill with 2 words, assert reset_n=0 for one edge -> out_valid=0, in_ready=1, txn_cnt=0, x_tap=0. A subsequent hold-mode push outputs 0.
